inbuf_polyphase_addrgen: RTL and testbench

// Parametrised address generator for the resampler input buffer (interpolate by NUM_PHASES,

---
 rtl/inbuf_polyphase_addrgen.sv | 108 ++++++++++
 tb/tb_inbuf_polyphase_addrgen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/inbuf_polyphase_addrgen.sv
// inbuf_polyphase_addrgen: polyphase tap/coefficient address generator for the resampler input buffer
// Fills a frame on port A, walks FIR tap bursts on port B, then copies the history tail to the bottom.
module inbuf_polyphase_addrgen #(
  parameter int ADDR_W     = 10,
  parameter int PHASE_W    = 2,
  parameter int NUM_PHASES = 3,
  parameter int DECIM      = 4,
  parameter int TAPS       = 7,
  parameter int HIST       = 21,
  parameter int FRAME_END  = 779
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               fir_start,
  input  logic               out_wea,
  output logic               buf_wea,
  output logic [ADDR_W-1:0]  buf_addra,
  output logic [ADDR_W-1:0]  buf_addrb,
  output logic [PHASE_W-1:0] fir_phase,
  output logic               tap_valid,
  output logic               tap_last,
  output logic               process_start,
  output logic               copy_end,
  output logic               overflow
);
  localparam int CW = $clog2(HIST + 1);
  localparam logic [CW-1:0]     TAP_MAX  = CW'(TAPS - 1);
  localparam logic [CW-1:0]     CNT_HIST = CW'(HIST);
  localparam logic [ADDR_W-1:0] FE_A     = ADDR_W'(FRAME_END);
  localparam logic [ADDR_W-1:0] HIST_A   = ADDR_W'(HIST);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(FRAME_END + 1 - HIST);
  localparam logic [ADDR_W:0]   FE_B     = (ADDR_W+1)'(FRAME_END);
  localparam logic [ADDR_W:0]   REBASE_B = (ADDR_W+1)'(FRAME_END + 1 - HIST);
  localparam logic [31:0]       NP_U     = NUM_PHASES;
  localparam logic [31:0]       DEC_U    = DECIM;

  typedef enum logic [2:0] {FILL, ARM, S_TAPS, WAIT_ACK, COPY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     base_q, base_d, nxt_base;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         sum;
  logic                fill_wr, frame_full, ack, copy_wr, copy_done;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q    <= FILL;
      wr_addr_q  <= HIST_A;
      base_q     <= (ADDR_W+1)'(HIST - 1);
      phase_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      base_q     <= base_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:     state_d = frame_full ? ARM : FILL;
      ARM:      state_d = fir_start ? S_TAPS : ARM;
      S_TAPS:   state_d = (cnt_q == TAP_MAX) ? WAIT_ACK : S_TAPS;
      WAIT_ACK: state_d = !out_wea ? WAIT_ACK : (nxt_base > FE_B) ? COPY : S_TAPS;
      COPY:     state_d = copy_done ? FILL : COPY;
      default:  state_d = FILL;
    endcase
  end

  // Phase advances by DECIM; whole multiples of NUM_PHASES spill into the tap base.
  always_comb begin
    sum        = 32'(phase_q) + DEC_U;
    nxt_base   = base_q + (ADDR_W+1)'(sum / NP_U);
    fill_wr    = state_q == FILL && in_valid;
    frame_full = fill_wr && wr_addr_q == FE_A;
    ack        = state_q == WAIT_ACK && out_wea;
    copy_wr    = state_q == COPY && cnt_q != '0;
    copy_done  = state_q == COPY && cnt_q == CNT_HIST;
    wr_addr_d  = !fill_wr ? wr_addr_q : frame_full ? HIST_A : wr_addr_q + 1'b1;
    cnt_d      = ((state_q == S_TAPS && cnt_q != TAP_MAX) || (state_q == COPY && !copy_done)) ? cnt_q + 1'b1 : '0;
    phase_d    = ack ? PHASE_W'(sum % NP_U) : phase_q;
    base_d     = ack ? nxt_base : copy_done ? base_q - REBASE_B : base_q;
    overflow_d = overflow_q | (in_valid && state_q != FILL);
  end

  // Copy writes trail the reads by one cycle to cover the RAM read latency.
  always_comb begin
    buf_wea       = fill_wr || copy_wr;
    buf_addra     = copy_wr ? ADDR_W'(cnt_q - 1'b1) : wr_addr_q;
    buf_addrb     = state_q == S_TAPS ? ADDR_W'(base_q - (ADDR_W+1)'(cnt_q)) :
                    (state_q == COPY && !copy_done) ? SRC_A + ADDR_W'(cnt_q) : '0;
    fir_phase     = phase_q;
    tap_valid     = state_q == S_TAPS;
    tap_last      = state_q == S_TAPS && cnt_q == TAP_MAX;
    process_start = frame_full;
    copy_end      = copy_done;
    overflow      = overflow_q;
  end
endmodule

// File: tb/tb_inbuf_polyphase_addrgen.sv
// tb_inbuf_polyphase_addrgen: table and scoreboard checks of fill, tap bursts, phase walk, copy, overflow, reset
module tb_inbuf_polyphase_addrgen;
  localparam int AW = 10, NP = 3, DEC = 4, NT = 7, HI = 21, FE = 779;

  logic sys_clk = 0, reset = 0, in_valid = 0, fir_start = 0, out_wea = 0;
  logic buf_wea, tap_valid, tap_last, process_start, copy_end, overflow;
  logic [AW-1:0] buf_addra, buf_addrb;
  logic [1:0] fir_phase;
  logic in_valid2 = 0, fir_start2 = 0, out_wea2 = 0;
  logic a_wea, a_tv, a_tl, a_ps, a_ce, a_ov, b_wea, b_tv, b_tl, b_ps, b_ce, b_ov;
  logic [5:0] a_addra, a_addrb, b_addra, b_addrb;
  logic [0:0] a_ph, b_ph;

  int checks = 0, failures = 0;

  typedef struct {int addrb; int phase; bit last;} tap_t;
  tap_t q[$];

  typedef struct {int b; int p;} burst_t;
  burst_t tbl[4];
  typedef struct {int b1; int b2; int p2;} aux_t;
  aux_t aux_tbl[4];

  always #5 sys_clk = ~sys_clk;

  inbuf_polyphase_addrgen #(.ADDR_W(AW), .PHASE_W(2), .NUM_PHASES(NP), .DECIM(DEC), .TAPS(NT), .HIST(HI), .FRAME_END(FE)) dut (
    .sys_clk(sys_clk), .reset(reset), .in_valid(in_valid), .fir_start(fir_start), .out_wea(out_wea),
    .buf_wea(buf_wea), .buf_addra(buf_addra), .buf_addrb(buf_addrb), .fir_phase(fir_phase),
    .tap_valid(tap_valid), .tap_last(tap_last), .process_start(process_start), .copy_end(copy_end), .overflow(overflow));

  inbuf_polyphase_addrgen #(.ADDR_W(6), .PHASE_W(1), .NUM_PHASES(1), .DECIM(1), .TAPS(3), .HIST(8), .FRAME_END(40)) u_a (
    .sys_clk(sys_clk), .reset(reset), .in_valid(in_valid2), .fir_start(fir_start2), .out_wea(out_wea2),
    .buf_wea(a_wea), .buf_addra(a_addra), .buf_addrb(a_addrb), .fir_phase(a_ph),
    .tap_valid(a_tv), .tap_last(a_tl), .process_start(a_ps), .copy_end(a_ce), .overflow(a_ov));

  inbuf_polyphase_addrgen #(.ADDR_W(6), .PHASE_W(1), .NUM_PHASES(2), .DECIM(5), .TAPS(3), .HIST(8), .FRAME_END(40)) u_b (
    .sys_clk(sys_clk), .reset(reset), .in_valid(in_valid2), .fir_start(fir_start2), .out_wea(out_wea2),
    .buf_wea(b_wea), .buf_addra(b_addra), .buf_addrb(b_addrb), .fir_phase(b_ph),
    .tap_valid(b_tv), .tap_last(b_tl), .process_start(b_ps), .copy_end(b_ce), .overflow(b_ov));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every tap the DUT presents must match the oldest expected entry.
  always @(negedge sys_clk) begin
    if (reset && tap_valid) begin
      if (q.size() == 0) chk("tap_unexpected", int'(buf_addrb), -1);
      else begin
        tap_t e;
        e = q.pop_front();
        chk("tap_addrb", int'(buf_addrb), e.addrb);
        chk("tap_phase", int'(fir_phase), e.phase);
        chk("tap_last", int'(tap_last), int'(e.last));
      end
    end
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    @(negedge sys_clk);
    chk({tag, "_addra"}, int'(buf_addra), HI);
    chk({tag, "_wea"}, int'(buf_wea), 0);
    chk({tag, "_addrb"}, int'(buf_addrb), 0);
    chk({tag, "_phase"}, int'(fir_phase), 0);
    chk({tag, "_tap_valid"}, int'(tap_valid), 0);
    chk({tag, "_tap_last"}, int'(tap_last), 0);
    chk({tag, "_process_start"}, int'(process_start), 0);
    chk({tag, "_copy_end"}, int'(copy_end), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic fill(input bit detail);
    int ps = 0;
    in_valid = 1;
    for (int i = 0; i <= FE - HI; i++) begin
      @(negedge sys_clk);
      if (detail) begin
        chk("fill_addra", int'(buf_addra), HI + i);
        chk("fill_wea", int'(buf_wea), 1);
        chk("fill_process_start", int'(process_start), int'(i == FE - HI));
      end
      ps += int'(process_start);
      tick();
    end
    in_valid = 0;
    chk("process_start_count", ps, 1);
  endtask

  task automatic burst(input bit use_start, input int b, input int p, input bit ov);
    for (int t = 0; t < NT; t++) q.push_back('{(b - t) & ((1 << AW) - 1), p, t == NT - 1});
    if (use_start) fir_start = 1; else out_wea = 1;
    tick();
    fir_start = 0;
    out_wea = 0;
    for (int t = 0; t < NT; t++) begin
      if (ov && t == 2) in_valid = 1;
      @(negedge sys_clk);
      if (ov && t == 2) begin
        chk("ovf_no_wea", int'(buf_wea), 0);
        chk("ovf_addra_held", int'(buf_addra), HI);
      end
      tick();
      in_valid = 0;
    end
    chk("taps_consumed", q.size(), 0);
  endtask

  task automatic continue_to_copy(inout int b, inout int p);
    bit done = 0;
    for (int n = 0; n < 2000 && !done; n++) begin
      int s = p + DEC;
      p = s % NP;
      b = b + s / NP;
      if (b > FE) begin
        out_wea = 1;
        tick();
        out_wea = 0;
        done = 1;
      end else burst(0, b, p, 0);
    end
    chk("reached_copy", int'(done), 1);
  endtask

  initial begin
    int b, p, ps_a, ps_b;
    tbl[0] = '{20, 0}; tbl[1] = '{21, 1}; tbl[2] = '{22, 2}; tbl[3] = '{24, 0};
    aux_tbl[0] = '{7, 7, 0}; aux_tbl[1] = '{8, 9, 1}; aux_tbl[2] = '{9, 12, 0}; aux_tbl[3] = '{10, 14, 1};
    repeat (2) tick();
    check_reset("reset");
    tick();
    reset = 1;
    fill(1);
    for (int i = 0; i < 4; i++) burst(i == 0, tbl[i].b, tbl[i].p, 0);
    b = 24;
    p = 0;
    continue_to_copy(b, p);
    for (int k = 0; k <= HI; k++) begin
      @(negedge sys_clk);
      chk("copy_addrb", int'(buf_addrb), k < HI ? FE + 1 - HI + k : 0);
      chk("copy_wea", int'(buf_wea), int'(k >= 1));
      if (k >= 1) chk("copy_addra", int'(buf_addra), k - 1);
      chk("copy_end", int'(copy_end), int'(k == HI));
      tick();
    end
    @(negedge sys_clk);
    chk("post_copy_addra", int'(buf_addra), HI);
    chk("post_copy_end", int'(copy_end), 0);
    tick();
    b = b - (FE + 1 - HI);
    fill(0);
    burst(1, b, p, 1);
    @(negedge sys_clk);
    chk("overflow_set", int'(overflow), 1);
    tick();
    continue_to_copy(b, p);
    repeat (5) tick();
    reset = 0;
    tick();
    check_reset("reset_mid_copy");
    tick();
    reset = 1;
    ps_a = 0;
    ps_b = 0;
    in_valid2 = 1;
    for (int i = 0; i < 33; i++) begin
      @(negedge sys_clk);
      ps_a += int'(a_ps);
      ps_b += int'(b_ps);
      tick();
    end
    in_valid2 = 0;
    chk("aux_a_process_start", ps_a, 1);
    chk("aux_b_process_start", ps_b, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) fir_start2 = 1; else out_wea2 = 1;
      tick();
      fir_start2 = 0;
      out_wea2 = 0;
      @(negedge sys_clk);
      chk("np1_addrb", int'(a_addrb), aux_tbl[i].b1);
      chk("np1_phase", int'(a_ph), 0);
      chk("np1_tap_valid", int'(a_tv), 1);
      chk("np2_addrb", int'(b_addrb), aux_tbl[i].b2);
      chk("np2_phase", int'(b_ph), aux_tbl[i].p2);
      repeat (3) @(posedge sys_clk);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
